mc_ctrl_hs: RTL and testbench
=============================

Name: mc_ctrl_hs

Overview:
Next-generation multicycle RV32I control unit. It replaces the fixed-latency main FSM, ALU decoder and immediate decoder with one parametrised FSM. The FSM supports variable-latency memory through a req/ready handshake, with a timeout.
- Instruction coverage adds lui, auipc, jalr, bne, xor and the shift group (sll/srl/sra, R and I forms).
- Illegal opcodes are trapped into a halt state.
- Drives the existing unified-memory multicycle datapath, extended with a 4-bit ALU control and a 3-bit immediate select.

Parameters:
ALU_CTRL_W, 4, width of alu_control; must be >= 4.
IMM_SRC_W, 3, width of imm_src; must be >= 3.
MAX_WAIT, 16, maximum cycles mem_req may wait for mem_ready; 0 disables the timeout.
CNT_W, 32, width of the retire counter (optional feature only).

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
op  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted/completed current access
mem_req  out  1  memory access request
pc_write  out  1  PC register enable
ir_write  out  1  IR/OldPC enable
reg_write  out  1  regfile write enable
mem_write  out  1  memory write strobe
adr_src  out  1  0=PC, 1=Result
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  out  2  00 PC, 01 OldPC, 10 A
alu_src_b  out  2  00 WriteData, 01 ImmExt, 10 const 4
imm_src  out  IMM_SRC_W  000 I, 001 S, 010 B, 011 J, 100 U
alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sll, 7 srl, 8 sra, 9 passB
illegal  out  1  sticky: illegal opcode trapped
mem_timeout  out  1  sticky: handshake timeout
instret  out  CNT_W  retired count (MC_PERF_CNT_EN only)

Behaviour:
- One-hot state register; reset forces FETCH.
- While reset is high: mem_req, pc_write, ir_write, reg_write, mem_write, illegal and mem_timeout are all 0.
- States and actions (unlisted strobes 0):
  - FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10. Holds until mem_ready. On the mem_ready cycle only: ir_write=1, pc_write=1, then go to DECODE.
  - DECODE: a=01, b=01, add (ALUOut<=OldPC+imm). Dispatch by op:
    - lw/sw -> MEMADR
    - R 0110011 -> EXEC_R
    - I 0010011 -> EXEC_I
    - jal -> JAL
    - jalr 1100111 -> JALR_ADR
    - branch -> BRANCH
    - lui 0110111 -> LUI
    - auipc 0010111 -> ALUWB
    - any other op -> HALT, and set illegal.
  - MEMADR: a=10, b=01, add. Goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then MEMWB.
  - MEMWRITE: mem_req=1, adr_src=1, mem_write=1 held while waiting. Goes to FETCH on mem_ready.
  - MEMWB: result_src=01, reg_write=1. Goes to FETCH.
  - EXEC_R: a=10, b=00. EXEC_I: a=10, b=01. Both go to ALUWB.
  - ALUWB: result_src=00, reg_write=1. Goes to FETCH.
  - JALR_ADR: a=10, b=01, add. Goes to JAL.
  - JAL: a=01, b=10, add, result_src=00, pc_write=1. Goes to ALUWB.
  - BRANCH: a=10, b=00, sub, result_src=00. pc_write = zero XOR funct3[0] (beq/bne). Goes to FETCH.
  - LUI: b=01, passB. Goes to ALUWB.
  - HALT: terminal; only reset exits.
- imm_src by op:
  - I for I-type, lw and jalr
  - S for sw
  - B for branch
  - J for jal
  - U for lui/auipc
  - 000 otherwise.
- ALU decode in EXEC_R/EXEC_I, by funct3:
  - 000: sub only if R-type and funct7b5, else add
  - 001: sll
  - 010: slt
  - 100: xor
  - 101: sra if funct7b5, else srl
  - 110: or
  - 111: and
  - 011: add
- Timeout:
  - A wait counter clears on entering any mem_req state and on mem_ready.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - When the counter reaches MAX_WAIT (MAX_WAIT > 0): go to HALT, set mem_timeout; no write strobe is asserted that cycle.
- Simultaneous events: mem_ready in the same cycle the count hits MAX_WAIT means the access completes and no timeout is raised.
- Async reset mid-access: mem_req drops immediately and the wait counter clears.

Optional Feature:
MC_PERF_CNT_EN
- Defined: instret port present. Counter clears on reset and increments by 1 on each transition into FETCH from MEMWRITE, MEMWB, ALUWB or BRANCH. It wraps at 2^CNT_W.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- addi x1,x0,5 with mem_ready always 1 -> states FETCH, DECODE, EXEC_I, ALUWB; reg_write=1 only in ALUWB; alu_control=0.
- lw with mem_ready held low 3 cycles in FETCH and in MEMREAD (MAX_WAIT=16) -> ir_write/pc_write pulse only on the ready cycle; mem_req=1 for 4 cycles in each state; no timeout.
- bne, zero=0 -> pc_write=1 in BRANCH. Same with zero=1 -> pc_write=0. beq inverts both results.
- jalr -> JALR_ADR (a=10, b=01), JAL (pc_write=1), ALUWB (reg_write=1); total 5 cycles with ready=1.
- op=7'b1111111 -> HALT after DECODE, illegal=1; no strobes for 20 cycles; reset clears illegal and restarts FETCH.
- mem_ready stuck 0, MAX_WAIT=16 -> mem_timeout=1 after 16 wait cycles, HALT. With MC_PERF_CNT_EN: 3 retired addi -> instret=3.

Source files
------------

// File: rtl/mc_ctrl_hs.sv
// ---------------------------------------------------------------------------
// mc_ctrl_hs : multicycle RV32I control unit with a memory req/ready handshake
//
// One FSM drives the unified-memory multicycle datapath. It also decodes the
// ALU operation and selects the immediate format. Every memory access waits
// for mem_ready. A wait counter traps an access that never completes into
// HALT. Illegal opcodes are trapped into HALT as well.
//
// Optional build macro:
//   MC_PERF_CNT_EN : adds the instret port and a retired-instruction counter
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   op/funct3/funct7b5  instruction fields from the IR
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory accepted/completed the current access
//   mem_req             memory access request
//   pc_write, ir_write  PC / IR+OldPC enables
//   reg_write           register file write enable
//   mem_write           memory write strobe
//   adr_src             address mux (0 PC, 1 Result)
//   result_src          result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   alu_src_a/_b        ALU operand muxes
//   imm_src             immediate format (I,S,B,J,U)
//   alu_control         ALU operation
//   illegal             sticky, an illegal opcode was trapped
//   mem_timeout         sticky, a handshake timed out
//   instret             retired instruction count (MC_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
//
// state    | meaning
// ---------+-------------------------------------------------------------
// FETCH    | fetch request; PC+4 to PC and load IR on mem_ready
// DECODE   | ALUOut <= OldPC+imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1+imm (load/store address)
// MEMREAD  | load access, wait for mem_ready
// MEMWRITE | store access, write strobe held until mem_ready
// MEMWB    | write loaded data to rd
// EXEC_R   | register-register ALU op
// EXEC_I   | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// JALR_ADR | ALUOut <= rs1+imm (jalr target)
// JAL      | PC <= ALUOut, ALUOut <= OldPC+4
// BRANCH   | compare rs1-rs2, PC <= ALUOut if taken (beq/bne)
// LUI      | ALUOut <= imm
// HALT     | trapped (illegal opcode or timeout), only reset exits

module mc_ctrl_hs #(
    parameter int ALU_CTRL_W = 4,
    parameter int IMM_SRC_W  = 3,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  pc_write,
    output logic                  ir_write,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [IMM_SRC_W-1:0]  imm_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal,
    output logic                  mem_timeout
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      instret
`endif
);

    if (ALU_CTRL_W < 4) begin : g_chk_alu_w
        $error("mc_ctrl_hs: ALU_CTRL_W must be >= 4");
    end
    if (IMM_SRC_W < 3) begin : g_chk_imm_w
        $error("mc_ctrl_hs: IMM_SRC_W must be >= 3");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("mc_ctrl_hs: CNT_W must be >= 1");
    end
    if (MAX_WAIT < 0) begin : g_chk_max_wait
        $error("mc_ctrl_hs: MAX_WAIT must be >= 0");
    end

    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(9);

    localparam logic [IMM_SRC_W-1:0] IMM_I = IMM_SRC_W'(0);
    localparam logic [IMM_SRC_W-1:0] IMM_S = IMM_SRC_W'(1);
    localparam logic [IMM_SRC_W-1:0] IMM_B = IMM_SRC_W'(2);
    localparam logic [IMM_SRC_W-1:0] IMM_J = IMM_SRC_W'(3);
    localparam logic [IMM_SRC_W-1:0] IMM_U = IMM_SRC_W'(4);

    typedef enum logic [13:0] {
        S_FETCH    = 14'h0001,
        S_DECODE   = 14'h0002,
        S_MEMADR   = 14'h0004,
        S_MEMREAD  = 14'h0008,
        S_MEMWRITE = 14'h0010,
        S_MEMWB    = 14'h0020,
        S_EXEC_R   = 14'h0040,
        S_EXEC_I   = 14'h0080,
        S_ALUWB    = 14'h0100,
        S_JALR_ADR = 14'h0200,
        S_JAL      = 14'h0400,
        S_BRANCH   = 14'h0800,
        S_LUI      = 14'h1000,
        S_HALT     = 14'h2000
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                illegal_q, illegal_d;
    logic                timeout_q, timeout_d;

    logic                req_c, pcw_c, irw_c, rw_c, mw_c;
    logic                mem_state;
    logic                timeout_hit;
    logic [ALU_CTRL_W-1:0] alu_dec;

    // A completing access always wins over a timeout in the same cycle.
    assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                         (state_q == S_MEMWRITE);
    assign timeout_hit = (MAX_WAIT > 0) && mem_state && !mem_ready &&
                         (wait_q == WAIT_LIMIT);

    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_dec = ALU_SLL;
            3'b010:  alu_dec = ALU_SLT;
            3'b011:  alu_dec = ALU_ADD;
            3'b100:  alu_dec = ALU_XOR;
            3'b101:  alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_I, OP_LOAD, OP_JALR: imm_src = IMM_I;
            OP_STORE:               imm_src = IMM_S;
            OP_BRANCH:              imm_src = IMM_B;
            OP_JAL:                 imm_src = IMM_J;
            OP_LUI, OP_AUIPC:       imm_src = IMM_U;
            default:                imm_src = IMM_I;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        timeout_d   = timeout_q;
        req_c       = 1'b0;
        pcw_c       = 1'b0;
        irw_c       = 1'b0;
        rw_c        = 1'b0;
        mw_c        = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;

        case (state_q)
            S_FETCH: begin
                req_c      = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_ADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_ALUWB;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // op[5] separates store (0100011) from load (0000011)
                state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req_c   = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWRITE: begin
                req_c   = 1'b1;
                adr_src = 1'b1;
                mw_c    = !timeout_hit;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWB: begin
                result_src = 2'b01;
                rw_c       = 1'b1;
                state_d    = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a   = 2'b10;
                alu_control = alu_dec;
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = alu_dec;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                state_d = S_FETCH;
            end
            S_JALR_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pcw_c     = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
                // funct3[0] flips beq into bne
                pcw_c       = zero ^ funct3[0];
                state_d     = S_FETCH;
            end
            S_LUI: begin
                alu_src_b   = 2'b01;
                alu_control = ALU_PASSB;
                state_d     = S_ALUWB;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // Any state change (including entering a request state) restarts the count.
    always_comb begin
        wait_d = wait_q;
        if ((state_d != state_q) || mem_ready) begin
            wait_d = '0;
        end else if ((MAX_WAIT > 0) && req_c) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Strobes are masked by reset so a request drops as soon as reset rises.
    assign mem_req     = req_c & ~reset;
    assign pc_write    = pcw_c & ~reset;
    assign ir_write    = irw_c & ~reset;
    assign reg_write   = rw_c  & ~reset;
    assign mem_write   = mw_c  & ~reset;
    assign illegal     = illegal_q;
    assign mem_timeout = timeout_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] instret_q;
    logic             retire;

    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWRITE) || (state_q == S_MEMWB) ||
                     (state_q == S_ALUWB)    || (state_q == S_BRANCH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_hs : directed self-checking bench for mc_ctrl_hs (MAX_WAIT=16)
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 time
// unit later, well before the next rising edge.
// ---------------------------------------------------------------------------

module tb_mc_ctrl_hs;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal, mem_timeout;
`ifdef MC_PERF_CNT_EN
    logic [31:0] instret;
`endif

    mc_ctrl_hs #(
        .ALU_CTRL_W (4),
        .IMM_SRC_W  (3),
        .MAX_WAIT   (16),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .illegal     (illegal),
        .mem_timeout (mem_timeout)
`ifdef MC_PERF_CNT_EN
        ,
        .instret     (instret)
`endif
    );

    always #5 clk = ~clk;

    // strobes {mem_req, pc_write, ir_write, reg_write, mem_write}
    localparam logic [4:0] ST_NONE  = 5'b00000;
    localparam logic [4:0] ST_FRDY  = 5'b11100;
    localparam logic [4:0] ST_REQ   = 5'b10000;
    localparam logic [4:0] ST_WB    = 5'b00010;
    localparam logic [4:0] ST_MW    = 5'b10001;
    localparam logic [4:0] ST_PC    = 5'b01000;
    // muxes {adr_src, result_src, alu_src_a, alu_src_b}
    localparam logic [6:0] M_FETCH  = 7'b0_10_00_10;
    localparam logic [6:0] M_DEC    = 7'b0_00_01_01;
    localparam logic [6:0] M_AIMM   = 7'b0_00_10_01;
    localparam logic [6:0] M_AREG   = 7'b0_00_10_00;
    localparam logic [6:0] M_ZERO   = 7'b0_00_00_00;
    localparam logic [6:0] M_MEM    = 7'b1_00_00_00;
    localparam logic [6:0] M_MEMWB  = 7'b0_01_00_00;
    localparam logic [6:0] M_JAL    = 7'b0_00_01_10;
    localparam logic [6:0] M_LUI    = 7'b0_00_00_01;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_imm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Check one cycle of outputs, then advance to 1 unit after the next edge.
    task automatic cyc(input string tag, input logic [4:0] e_stb,
                       input logic [6:0] e_mux, input logic [3:0] e_alu);
        #1;
        chk({tag, ".stb"}, {27'd0, mem_req, pc_write, ir_write, reg_write, mem_write},
            {27'd0, e_stb});
        chk({tag, ".mux"}, {25'd0, adr_src, result_src, alu_src_a, alu_src_b},
            {25'd0, e_mux});
        chk({tag, ".alu"}, {28'd0, alu_control}, {28'd0, e_alu});
        chk({tag, ".imm"}, {29'd0, imm_src}, {29'd0, exp_imm});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst.stb", {27'd0, mem_req, pc_write, ir_write, reg_write, mem_write}, 32'd0);
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
        chk("rst.timeout", {31'd0, mem_timeout}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_arith(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [3:0] e_alu);
        op = o; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1; exp_imm = 3'd0;
        cyc({name, ".fetch"}, ST_FRDY, M_FETCH, 4'd0);
        cyc({name, ".decode"}, ST_NONE, M_DEC, 4'd0);
        cyc({name, ".exec"}, ST_NONE, (o == 7'b0110011) ? M_AREG : M_AIMM, e_alu);
        cyc({name, ".aluwb"}, ST_WB, M_ZERO, 4'd0);
    endtask

    task automatic run_br(input string name, input logic [2:0] f3, input logic z,
                          input logic e_pw);
        op = 7'b1100011; funct3 = f3; zero = z; mem_ready = 1'b1; exp_imm = 3'd2;
        cyc({name, ".fetch"}, ST_FRDY, M_FETCH, 4'd0);
        cyc({name, ".decode"}, ST_NONE, M_DEC, 4'd0);
        cyc({name, ".branch"}, {1'b0, e_pw, 3'b000}, M_AREG, 4'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; op = 7'b0010011; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b0; mem_ready = 1'b0; exp_imm = 3'd0;
        @(posedge clk);
        #1;
        do_reset();

        // ALU decode across R and I forms
        run_arith("addi",    7'b0010011, 3'b000, 1'b0, 4'd0);
        run_arith("addi_f7", 7'b0010011, 3'b000, 1'b1, 4'd0);
        run_arith("sub",     7'b0110011, 3'b000, 1'b1, 4'd1);
        run_arith("add",     7'b0110011, 3'b000, 1'b0, 4'd0);
        run_arith("sll",     7'b0110011, 3'b001, 1'b0, 4'd6);
        run_arith("slti",    7'b0010011, 3'b010, 1'b0, 4'd5);
        run_arith("f3_011",  7'b0110011, 3'b011, 1'b0, 4'd0);
        run_arith("xor",     7'b0110011, 3'b100, 1'b0, 4'd4);
        run_arith("srli",    7'b0010011, 3'b101, 1'b0, 4'd7);
        run_arith("sra",     7'b0110011, 3'b101, 1'b1, 4'd8);
        run_arith("ori",     7'b0010011, 3'b110, 1'b0, 4'd3);
        run_arith("and",     7'b0110011, 3'b111, 1'b0, 4'd2);

        // lw with 3 wait cycles in FETCH and in MEMREAD
        op = 7'b0000011; funct3 = 3'b010; exp_imm = 3'd0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.fetch_wait", ST_REQ, M_FETCH, 4'd0);
        mem_ready = 1'b1;
        cyc("lw.fetch_rdy", ST_FRDY, M_FETCH, 4'd0);
        cyc("lw.decode", ST_NONE, M_DEC, 4'd0);
        cyc("lw.memadr", ST_NONE, M_AIMM, 4'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("lw.read_wait", ST_REQ, M_MEM, 4'd0);
        mem_ready = 1'b1;
        cyc("lw.read_rdy", ST_REQ, M_MEM, 4'd0);
        cyc("lw.memwb", ST_WB, M_MEMWB, 4'd0);
        chk("lw.timeout", {31'd0, mem_timeout}, 32'd0);

        // sw: ready arrives on the very cycle the count reaches 16 -> completes
        op = 7'b0100011; exp_imm = 3'd1;
        cyc("sw.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("sw.decode", ST_NONE, M_DEC, 4'd0);
        cyc("sw.memadr", ST_NONE, M_AIMM, 4'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("sw.write_wait", ST_MW, M_MEM, 4'd0);
        mem_ready = 1'b1;
        cyc("sw.write_edge_rdy", ST_MW, M_MEM, 4'd0);
        chk("sw.edge_no_timeout", {31'd0, mem_timeout}, 32'd0);

        // second sw times out in MEMWRITE; write strobe drops on that cycle
        cyc("sw2.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("sw2.decode", ST_NONE, M_DEC, 4'd0);
        cyc("sw2.memadr", ST_NONE, M_AIMM, 4'd0);
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("sw2.write_wait", ST_MW, M_MEM, 4'd0);
        chk("sw2.pre_timeout", {31'd0, mem_timeout}, 32'd0);
        cyc("sw2.timeout_cycle", ST_REQ, M_MEM, 4'd0);
        chk("sw2.timeout", {31'd0, mem_timeout}, 32'd1);
        cyc("sw2.halt", ST_NONE, M_ZERO, 4'd0);
        chk("sw2.illegal", {31'd0, illegal}, 32'd0);
        do_reset();

        // beq / bne resolution
        run_br("bne_z0", 3'b001, 1'b0, 1'b1);
        run_br("bne_z1", 3'b001, 1'b1, 1'b0);
        run_br("beq_z0", 3'b000, 1'b0, 1'b0);
        run_br("beq_z1", 3'b000, 1'b1, 1'b1);

        // jalr, jal, lui, auipc
        op = 7'b1100111; funct3 = 3'b000; exp_imm = 3'd0; mem_ready = 1'b1;
        cyc("jalr.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("jalr.decode", ST_NONE, M_DEC, 4'd0);
        cyc("jalr.adr", ST_NONE, M_AIMM, 4'd0);
        cyc("jalr.jal", ST_PC, M_JAL, 4'd0);
        cyc("jalr.aluwb", ST_WB, M_ZERO, 4'd0);
        op = 7'b1101111; exp_imm = 3'd3;
        cyc("jal.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("jal.decode", ST_NONE, M_DEC, 4'd0);
        cyc("jal.jal", ST_PC, M_JAL, 4'd0);
        cyc("jal.aluwb", ST_WB, M_ZERO, 4'd0);
        op = 7'b0110111; exp_imm = 3'd4;
        cyc("lui.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("lui.decode", ST_NONE, M_DEC, 4'd0);
        cyc("lui.lui", ST_NONE, M_LUI, 4'd9);
        cyc("lui.aluwb", ST_WB, M_ZERO, 4'd0);
        op = 7'b0010111; exp_imm = 3'd4;
        cyc("auipc.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("auipc.decode", ST_NONE, M_DEC, 4'd0);
        cyc("auipc.aluwb", ST_WB, M_ZERO, 4'd0);

        // illegal opcode traps to HALT
        op = 7'b1111111; exp_imm = 3'd0;
        cyc("ill.fetch", ST_FRDY, M_FETCH, 4'd0);
        cyc("ill.decode", ST_NONE, M_DEC, 4'd0);
        chk("ill.flag", {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            cyc("ill.halt", ST_NONE, M_ZERO, 4'd0);
        end
        do_reset();
        cyc("ill.restart", ST_REQ, M_FETCH, 4'd0);

        // async reset mid-access drops mem_req and clears the wait count
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) cyc("ar.fetch_wait", ST_REQ, M_FETCH, 4'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar.req_drop", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) cyc("ar.fetch_wait2", ST_REQ, M_FETCH, 4'd0);
        mem_ready = 1'b1;
        cyc("ar.fetch_edge_rdy", ST_FRDY, M_FETCH, 4'd0);
        chk("ar.no_timeout", {31'd0, mem_timeout}, 32'd0);

        // fetch stuck: timeout after 16 wait cycles
        do_reset();
        for (int i = 0; i < 16; i++) cyc("to.fetch_wait", ST_REQ, M_FETCH, 4'd0);
        chk("to.pre", {31'd0, mem_timeout}, 32'd0);
        cyc("to.timeout_cycle", ST_REQ, M_FETCH, 4'd0);
        chk("to.flag", {31'd0, mem_timeout}, 32'd1);
        cyc("to.halt", ST_NONE, M_ZERO, 4'd0);

`ifdef MC_PERF_CNT_EN
        do_reset();
        chk("perf.reset", instret, 32'd0);
        for (int i = 0; i < 3; i++) run_arith("perf.addi", 7'b0010011, 3'b000, 1'b0, 4'd0);
        chk("perf.instret", instret, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
